// File: rtl/vx_latency_mem.sv
// Fixed-latency memory responder for the Vortex mem_req/mem_rsp port: byte-enabled backing store
// plus an in-order pending-response queue. Define VX_LMEM_WRITE_RSP_EN to make writes respond too.
module vx_latency_mem #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 26,
  parameter int TAG_WIDTH       = 56,
  parameter int DEPTH_WORDS     = 64,
  parameter int LATENCY         = 30,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy,
  output logic                    addr_oob
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DW    = $clog2(LATENCY + 1);
  localparam int QW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic [DW-1:0]         dly;
  } entry_t;

  logic [DEPTH_WORDS-1:0][DATA_WIDTH-1:0] store_q, store_d;
  entry_t [MAX_OUTSTANDING-1:0]           q_q, q_d;
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          addr_oob_q, addr_oob_d;

  logic                  full, req_fire, push, pop, in_range;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] cur_word, wr_word, push_data;

  function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == CW'(MAX_OUTSTANDING));
  assign busy     = (count_q != '0);
  assign addr_oob = addr_oob_q;
  assign req_fire = mem_req_valid && mem_req_ready;

`ifdef VX_LMEM_WRITE_RSP_EN
  assign mem_req_ready = !reset && !full;
  assign push          = req_fire;
`else
  // Writes never occupy the queue, so only reads are held off when it is full.
  assign mem_req_ready = !reset && (!full || mem_req_rw);
  assign push          = req_fire && !mem_req_rw;
`endif

  assign mem_rsp_valid = busy && (q_q[head_q].dly == '0);
  assign mem_rsp_data  = busy ? q_q[head_q].data : '0;
  assign mem_rsp_tag   = busy ? q_q[head_q].tag  : '0;
  assign pop           = mem_rsp_valid && mem_rsp_ready;

  always_comb begin
    in_range = ({1'b0, mem_req_addr} < DEPTH_LIM);
    idx      = mem_req_addr[IW-1:0];
    cur_word = in_range ? store_q[idx] : '0;
    wr_word  = cur_word;
    for (int b = 0; b < BYTES; b++)
      if (mem_req_byteen[b]) wr_word[b*8 +: 8] = mem_req_data[b*8 +: 8];
    push_data = mem_req_rw ? '0 : cur_word;

    store_d = store_q;
    if (req_fire && mem_req_rw && in_range) store_d[idx] = wr_word;
    addr_oob_d = addr_oob_q || (req_fire && !in_range);

    q_d = q_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      if (q_d[i].dly != '0) q_d[i].dly = q_d[i].dly - 1'b1;
    // Stored pre-decremented: the acceptance edge itself counts as the first latency cycle.
    if (push) q_d[tail_q] = '{tag: mem_req_tag, data: push_data, dly: DW'(LATENCY - 1)};

    head_d = pop  ? nxt(head_q) : head_q;
    tail_d = push ? nxt(tail_q) : tail_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_q    <= '0;
      q_q        <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      addr_oob_q <= 1'b0;
    end else begin
      store_q    <= store_d;
      q_q        <= q_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      addr_oob_q <= addr_oob_d;
    end
  end
endmodule

// File: tb/tb_vx_latency_mem.sv
// Scoreboard bench for vx_latency_mem: expected responses queued at stimulus time, popped by a monitor.
module tb_vx_latency_mem;
  localparam int DW = 512, AW = 26, TW = 56, DEPTH = 64, LAT = 30, MAXO = 4, BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req_valid = 1'b0, mem_req_rw = 1'b0;
  logic [BW-1:0] mem_req_byteen = '0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [DW-1:0] mem_req_data = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_req_ready, mem_rsp_valid, busy, addr_oob;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready = 1'b1;

  always #5 clk = ~clk;

  vx_latency_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH_WORDS(DEPTH),
                   .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy), .addr_oob(addr_oob));

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, failures = 0;

  logic          hold_v = 1'b0;
  logic [TW-1:0] hold_tag;
  logic [DW-1:0] hold_data;

  // Response monitor: in-order scoreboard plus stability under backpressure.
  always @(negedge clk) begin
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        checks++;
        if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== hold_tag || mem_rsp_data !== hold_data) begin
          failures++;
          $display("FAIL rsp_hold valid=%b tag=%h required tag=%h", mem_rsp_valid, mem_rsp_tag, hold_tag);
        end
      end
      if (mem_rsp_valid === 1'b1 && mem_rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected tag=%h required no response", mem_rsp_tag);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_rsp_tag !== mon_e.tag || mem_rsp_data !== mon_e.data) begin
            failures++;
            $display("FAIL rsp_order tag=%h data_lo=%h required tag=%h data_lo=%h",
                     mem_rsp_tag, mem_rsp_data[63:0], mon_e.tag, mon_e.data[63:0]);
          end
        end
      end
      hold_v    = (mem_rsp_valid === 1'b1) && !mem_rsp_ready;
      hold_tag  = mem_rsp_tag;
      hold_data = mem_rsp_data;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                      input logic [DW-1:0] data, input logic [BW-1:0] be);
    int n = 0;
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr;
    mem_req_tag = tag; mem_req_data = data; mem_req_byteen = be;
    @(negedge clk);
    while (mem_req_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL req_timeout tag=%h ready=%b required 1", tag, mem_req_ready);
    end
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 500) begin @(posedge clk); n++; end
    #1;
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d busy=%b required 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_ready !== 1'b0) begin failures++; $display("FAIL ready_in_reset ready=%b required 0", mem_req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_rsp_valid, busy, addr_oob, mem_req_ready} !== 4'b0001 || mem_rsp_data !== '0 || mem_rsp_tag !== '0) begin
      failures++;
      $display("FAIL reset_state valid=%b busy=%b oob=%b ready=%b required 0 0 0 1",
               mem_rsp_valid, busy, addr_oob, mem_req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int early = 0;
    exp_q.push_back('{tag: TW'('h55), data: '0});
    send(1'b0, AW'(5), TW'('h55), '0, '0);
    for (int j = 0; j < LAT - 1; j++) begin
      @(negedge clk);
      if (mem_rsp_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin failures++; $display("FAIL latency_early cycles=%0d required 0", early); end
    @(negedge clk);
    checks++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TW'('h55)) begin
      failures++;
      $display("FAIL latency_exact valid=%b tag=%h required 1 55", mem_rsp_valid, mem_rsp_tag);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_byteen();
    logic [BW-1:0] be;
    logic [DW-1:0] w;
    be = '0; be[3:0] = 4'hF;
    send(1'b1, AW'(3), TW'(1), {BW{8'hA5}}, be);
    be = '0; be[7:4] = 4'hF;
    send(1'b1, AW'(3), TW'(2), {BW{8'h11}}, be);
    send(1'b1, AW'(3), TW'(3), {BW{8'hFF}}, '0);
    w = '0; w[31:0] = {4{8'hA5}}; w[63:32] = {4{8'h11}};
    exp_q.push_back('{tag: TW'('h33), data: w});
    send(1'b0, AW'(3), TW'('h33), '0, '0);
    // Write right behind the read: the read must keep the older contents.
    send(1'b1, AW'(3), TW'(4), {BW{8'hCC}}, '1);
    exp_q.push_back('{tag: TW'('h34), data: {BW{8'hCC}}});
    send(1'b0, AW'(3), TW'('h34), '0, '0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    mem_rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = AW'(10 + i); mem_req_tag = TW'(i);
      exp_q.push_back('{tag: TW'(i), data: '0});
      @(negedge clk);
      checks++;
      if (mem_req_ready !== (i <= 4)) begin
        failures++;
        $display("FAIL ready_full i=%0d ready=%b required %b", i, mem_req_ready, (i <= 4));
      end
      @(posedge clk); #1;
    end
    idle(LAT + 2);
    @(negedge clk);
    checks++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TW'(1) || busy !== 1'b1 || mem_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_state valid=%b tag=%h busy=%b ready=%b required 1 1 1 0",
               mem_rsp_valid, mem_rsp_tag, busy, mem_req_ready);
    end
    @(posedge clk); #1;
    mem_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TW'(k + 1)) begin
        failures++;
        $display("FAIL drain_seq k=%0d valid=%b tag=%h required 1 %0d", k, mem_rsp_valid, mem_rsp_tag, k + 1);
      end
      if (k < 2) begin
        checks++;
        if (mem_req_ready !== (k == 1)) begin
          failures++;
          $display("FAIL no_bypass k=%0d ready=%b required %b", k, mem_req_ready, (k == 1));
        end
      end
      @(posedge clk); #1;
      if (k == 1) mem_req_valid = 1'b0;
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{tag: TW'('h20 + i), data: (i == 0) ? {BW{8'hCC}} : '0});
      send(1'b0, AW'((i == 0) ? 3 : 7), TW'('h20 + i), '0, '0);
    end
    repeat (LAT - 3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TW'('h20 + k)) begin
        failures++;
        $display("FAIL b2b k=%0d valid=%b tag=%h required 1 %h", k, mem_rsp_valid, mem_rsp_tag, 'h20 + k);
      end
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_oob();
    send(1'b1, AW'(0), TW'(1), {BW{8'h5A}}, '1);
    @(negedge clk);
    checks++;
    if (addr_oob !== 1'b0) begin failures++; $display("FAIL oob_pre oob=%b required 0", addr_oob); end
    @(posedge clk); #1;
    exp_q.push_back('{tag: TW'(7), data: '0});
    send(1'b0, AW'(DEPTH), TW'(7), '0, '0);
    @(negedge clk);
    checks++;
    if (addr_oob !== 1'b1) begin failures++; $display("FAIL oob_set oob=%b required 1", addr_oob); end
    @(posedge clk); #1;
    send(1'b1, AW'(DEPTH), TW'(8), {BW{8'hFF}}, '1);
    exp_q.push_back('{tag: TW'(9), data: {BW{8'h5A}}});
    send(1'b0, AW'(0), TW'(9), '0, '0);
    wait_drain();
    checks++;
    if (addr_oob !== 1'b1) begin failures++; $display("FAIL oob_sticky oob=%b required 1", addr_oob); end
  endtask

  task automatic test_reset_midop();
    send(1'b0, AW'(0), TW'('hA1), '0, '0);
    send(1'b0, AW'(1), TW'('hA2), '0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, mem_req_ready, mem_rsp_valid, addr_oob} !== 4'b0100) begin
      failures++;
      $display("FAIL midop_reset busy=%b ready=%b valid=%b oob=%b required 0 1 0 0",
               busy, mem_req_ready, mem_rsp_valid, addr_oob);
    end
    @(posedge clk); #1;
    idle(LAT + 5);
    exp_q.push_back('{tag: TW'('hA3), data: '0});
    send(1'b0, AW'(0), TW'('hA3), '0, '0);
    wait_drain();
  endtask

  task automatic test_write_rsp();
    int busy_hits = 0;
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < MAXO; i++) begin
      exp_q.push_back('{tag: TW'('h30 + i), data: '0});
      send(1'b0, AW'(20 + i), TW'('h30 + i), '0, '0);
    end
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = AW'(1);
    mem_req_tag = TW'('h40); mem_req_data = {BW{8'h77}}; mem_req_byteen = '1;
    @(negedge clk);
    checks++;
`ifdef VX_LMEM_WRITE_RSP_EN
    if (mem_req_ready !== 1'b0) begin failures++; $display("FAIL write_full ready=%b required 0", mem_req_ready); end
`else
    if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL write_full ready=%b required 1", mem_req_ready); end
`endif
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b1;
    wait_drain();
`ifdef VX_LMEM_WRITE_RSP_EN
    exp_q.push_back('{tag: TW'(9), data: '0});
    send(1'b1, AW'(2), TW'(9), {BW{8'h12}}, '1);
    wait_drain();
    exp_q.push_back('{tag: TW'('h41), data: '0});
`else
    send(1'b1, AW'(2), TW'(9), {BW{8'h12}}, '1);
    for (int j = 0; j < LAT + 5; j++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hits++;
    end
    checks++;
    if (busy_hits != 0) begin failures++; $display("FAIL write_no_rsp busy_cycles=%0d required 0", busy_hits); end
    @(posedge clk); #1;
    exp_q.push_back('{tag: TW'('h41), data: {BW{8'h77}}});
`endif
    send(1'b0, AW'(1), TW'('h41), '0, '0);
`ifdef VX_LMEM_WRITE_RSP_EN
    exp_q.push_back('{tag: TW'('h42), data: {BW{8'h12}}});
`else
    exp_q.push_back('{tag: TW'('h42), data: {BW{8'h12}}});
`endif
    send(1'b0, AW'(2), TW'('h42), '0, '0);
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_byteen();
    test_backpressure();
    test_back_to_back();
    test_oob();
    test_reset_midop();
    test_write_rsp();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL leftover pending=%0d required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vx_latency_mem.md
Name: vx_latency_mem

Overview:
- Synthesizable, parametrised memory-side responder for the Vortex top-level mem_req/mem_rsp interface.
- Replaces fixed-delay, single-request bench response logic with a backing store that supports:
  - byte-enable writes
  - a configurable fixed latency
  - up to MAX_OUTSTANDING in-flight reads, answered in order
- Sits directly on the GPU memory port in simulation and FPGA bring-up builds.

Parameters:
- DATA_WIDTH, 512, memory word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 26, word address width.
- TAG_WIDTH, 56, request tag width.
- DEPTH_WORDS, 64, number of backing words; valid addresses are 0..DEPTH_WORDS-1.
- LATENCY, 30, cycles from request acceptance to earliest response valid; must be >= 1.
- MAX_OUTSTANDING, 4, pending-response queue depth; must be >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req_valid  in  1  request valid.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_byteen  in  DATA_WIDTH/8  write byte enables.
- mem_req_addr  in  ADDR_WIDTH  word address.
- mem_req_data  in  DATA_WIDTH  write data.
- mem_req_tag  in  TAG_WIDTH  request tag.
- mem_req_ready  out  1  request accepted when valid && ready.
- mem_rsp_valid  out  1  response valid.
- mem_rsp_data  out  DATA_WIDTH  read data.
- mem_rsp_tag  out  TAG_WIDTH  tag of the answered request.
- mem_rsp_ready  in  1  response consumed when valid && ready.
- busy  out  1  any response pending.
- addr_oob  out  1  sticky flag; some request hit an out-of-range address.

Behaviour:
- Reset (synchronous, active-high, one cycle sufficient):
  - queue empty; count = 0.
  - mem_req_ready = 0 while reset is high.
  - mem_rsp_valid, mem_rsp_data, mem_rsp_tag, busy, addr_oob = 0.
  - backing store cleared to zero.
  - A reset asserted mid-operation drops all pending responses; none are emitted afterwards.
- mem_req_ready:
  - equals !reset && (count < MAX_OUTSTANDING).
  - No same-cycle pop/push bypass: when full, ready = 0 even if the head pops that cycle.
- Write accepted:
  - Store updated at that clock edge.
  - Only bytes with byteen = 1 change; byteen = 0 on every byte is a legal no-op.
  - No queue entry is created (see Optional Feature).
- Read accepted:
  - Enqueue {tag, data, delay = LATENCY}.
  - data is the store contents at the acceptance edge, i.e. before any later write.
- Out of bounds (addr >= DEPTH_WORDS):
  - Writes are dropped.
  - Reads return all-zero data with the correct tag.
  - addr_oob is set at the acceptance edge and held until reset.
- Delay counters:
  - Each queued entry's delay counter decrements every cycle and saturates at 0.
  - Width is $clog2(LATENCY+1).
- Response:
  - mem_rsp_valid = queue non-empty && head delay == 0.
  - Read accepted at edge N makes mem_rsp_valid high in the cycle after edge N+LATENCY-1; LATENCY = 1 gives a response in the very next cycle.
  - Back-to-back reads accepted on consecutive cycles respond on consecutive cycles when mem_rsp_ready is held high.
- Ordering: responses are strictly in acceptance order.
- Backpressure:
  - While mem_rsp_valid && !mem_rsp_ready, data and tag hold stable.
  - Younger entries keep counting down.
- Pop and push in the same cycle (non-full): count is unchanged; the new entry is placed at the tail.
- busy = (count != 0).
- Outputs mem_rsp_data and mem_rsp_tag are driven from the head entry and are zero when the queue is empty.

Optional Feature:
- Macro: VX_LMEM_WRITE_RSP_EN.
- Defined:
  - Accepted writes also enqueue an entry with their tag and all-zero data.
  - They obey the same latency, ordering and backpressure as reads and count toward MAX_OUTSTANDING.
- Undefined:
  - Writes never produce responses and never occupy the queue.
  - A write is accepted even when the queue is full.
  - mem_req_ready gating applies to reads only: ready = !reset && (!full || mem_req_rw).

Test Plan:
1. Reset then idle → all outputs 0, mem_req_ready = 1 one cycle after reset deasserts; read of addr 5 returns 0 with its tag, mem_rsp_valid exactly LATENCY cycles after acceptance.
2. Write addr 3, data 0xA5 repeated, byteen 0x...0F; then write addr 3 data 0x11 repeated, byteen 0x...F0; read addr 3 → low 4 bytes 0xA5, bytes 4-7 0x11, rest 0.
3. MAX_OUTSTANDING = 4, issue 5 consecutive reads tags 1..5 with mem_rsp_ready = 0 → ready drops after 4th; 5th stalls; releasing rsp_ready yields tags 1,2,3,4,5 in order, one per cycle.
4. Read addr DEPTH_WORDS (64), tag 0x7 → response data 0, tag 0x7, addr_oob = 1 and stays 1 until reset; a following write to 64 leaves addr 0 unchanged.
5. Two reads in flight, assert reset for 1 cycle → no responses emitted; busy = 0, count = 0, mem_req_ready = 1 next cycle.
6. VX_LMEM_WRITE_RSP_EN defined: write tag 0x9 → response tag 0x9, data 0 after LATENCY cycles. Undefined: no response to the write, busy stays 0.
